// File: rtl/lstm_seq_ctrl.sv
// rtl/lstm_seq_ctrl.sv - LSTM layer sequencer: MAC row stepping, activation, cell update, h writeback
// Walks t -> j -> gate -> k, issuing operand/weight addresses and datapath enables.
module lstm_seq_ctrl #(
  parameter int GATES   = 4,
  parameter int IWIDTH  = 8,
  parameter int HWIDTH  = 8,
  parameter int TWIDTH  = 10,
  parameter int AWIDTH  = 16,
  parameter int ACT_LAT = 2,
  localparam int GW     = (GATES > 1) ? $clog2(GATES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [IWIDTH-1:0] in_size,
  input  logic [HWIDTH-1:0] hid_size,
  input  logic [TWIDTH-1:0] step_num,
  input  logic              stall,
  output logic              busy,
  output logic              ack,
  output logic [GW-1:0]     gate_sel,
  output logic              op_sel,
  output logic [AWIDTH-1:0] op_addr,
  output logic [AWIDTH-1:0] w_addr,
  output logic              mac_clear,
  output logic              mac_en,
  output logic              act_en,
  output logic              cell_en,
  output logic              h_we,
  output logic [HWIDTH-1:0] h_addr,
  output logic [TWIDTH-1:0] t_cnt
);

  localparam int KW = ((IWIDTH > HWIDTH) ? IWIDTH : HWIDTH) + 1;
  localparam int SW = KW + AWIDTH;
  localparam int CW = (ACT_LAT > 1) ? $clog2(ACT_LAT) : 1;

  localparam logic [HWIDTH-1:0] H_ONE  = 1;
  localparam logic [TWIDTH-1:0] T_ONE  = 1;
  localparam logic [KW-1:0]     K_ONE  = 1;
  localparam logic [AWIDTH-1:0] A_ONE  = 1;
  localparam logic [CW-1:0]     C_ONE  = 1;
  localparam logic [GW-1:0]     G_ONE  = 1;
  localparam logic [GW-1:0]     G_LAST = GW'(GATES - 1);
  localparam logic [CW-1:0]     C_LAST = CW'(ACT_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_CELL, S_OUT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;

  logic [IWIDTH-1:0] r_in;
  logic [HWIDTH-1:0] r_hid;
  logic [TWIDTH-1:0] r_steps;
  logic [HWIDTH-1:0] r_j;
  logic [GW-1:0]     r_g;
  logic [KW-1:0]     r_k;
  logic [TWIDTH-1:0] r_t;
  logic [AWIDTH-1:0] r_w;
  logic [AWIDTH-1:0] r_xbase;
  logic [CW-1:0]     r_act;
  logic              r_op_sel_q;
  logic [AWIDTH-1:0] r_op_addr_q;

  logic [KW-1:0]     w_k_inc;
  logic [KW-1:0]     w_in_k;
  logic [KW-1:0]     w_klen;
  logic              w_k_last;
  logic              w_act_last;
  logic              w_g_last;
  logic              w_j_last;
  logic              w_t_last;
  logic              w_zero_cfg;
  logic [SW-1:0]     w_kx;
  logic [SW-1:0]     w_inx;
  logic [SW-1:0]     w_xbx;
  logic [SW-1:0]     w_x_sum;
  logic [SW-1:0]     w_h_off;
  logic [SW-1:0]     w_xb_next;
  logic              w_is_h;
  logic [AWIDTH-1:0] w_op_addr_now;

  assign w_k_inc    = r_k + K_ONE;
  assign w_in_k     = {{(KW-IWIDTH){1'b0}}, r_in};
  assign w_klen     = w_in_k + {{(KW-HWIDTH){1'b0}}, r_hid};
  assign w_k_last   = (w_k_inc == w_klen);
  assign w_act_last = (r_act == C_LAST);
  assign w_g_last   = (r_g == G_LAST);
  assign w_j_last   = ((r_j + H_ONE) == r_hid);
  assign w_t_last   = ((r_t + T_ONE) == r_steps);
  assign w_zero_cfg = (hid_size == '0) || (step_num == '0);

  // Address arithmetic is done wide and truncated so x_base and w_addr wrap mod 2^AWIDTH.
  assign w_kx          = {{AWIDTH{1'b0}}, r_k};
  assign w_inx         = {{(SW-IWIDTH){1'b0}}, r_in};
  assign w_xbx         = {{KW{1'b0}}, r_xbase};
  assign w_x_sum       = w_xbx + w_kx;
  assign w_h_off       = w_kx - w_inx;
  assign w_xb_next     = w_xbx + w_inx;
  assign w_is_h        = (r_k >= w_in_k);
  assign w_op_addr_now = w_is_h ? w_h_off[AWIDTH-1:0] : w_x_sum[AWIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!stall) begin
      case (r_state)
        S_IDLE:  if (req) w_next = w_zero_cfg ? S_DONE : S_MAC;
        S_MAC:   if (w_k_last) w_next = S_ACT;
        S_ACT:   if (w_act_last) w_next = w_g_last ? S_CELL : S_MAC;
        S_CELL:  w_next = S_OUT;
        S_OUT:   w_next = (w_j_last && w_t_last) ? S_DONE : S_MAC;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    ack       = (r_state == S_DONE) && !stall;
    mac_en    = (r_state == S_MAC) && !stall;
    mac_clear = (r_state == S_MAC) && !stall && (r_k == '0);
    act_en    = (r_state == S_ACT) && !stall && (r_act == '0);
    cell_en   = (r_state == S_CELL) && !stall;
    h_we      = (r_state == S_OUT) && !stall;
    op_sel    = r_op_sel_q;
    op_addr   = r_op_addr_q;
    if (r_state == S_MAC) begin
      op_sel  = w_is_h;
      op_addr = w_op_addr_now;
    end
  end

  assign gate_sel = r_g;
  assign w_addr   = r_w;
  assign h_addr   = r_j;
  assign t_cnt    = r_t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in        <= '0;
      r_hid       <= '0;
      r_steps     <= '0;
      r_j         <= '0;
      r_g         <= '0;
      r_k         <= '0;
      r_t         <= '0;
      r_w         <= '0;
      r_xbase     <= '0;
      r_act       <= '0;
      r_op_sel_q  <= 1'b0;
      r_op_addr_q <= '0;
    end else if (!stall) begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_in    <= in_size;
            r_hid   <= hid_size;
            r_steps <= step_num;
            r_j     <= '0;
            r_g     <= '0;
            r_k     <= '0;
            r_t     <= '0;
            r_w     <= '0;
            r_xbase <= '0;
            r_act   <= '0;
          end
        end
        S_MAC: begin
          r_w         <= r_w + A_ONE;
          r_k         <= w_k_last ? '0 : w_k_inc;
          r_op_sel_q  <= w_is_h;
          r_op_addr_q <= w_op_addr_now;
        end
        S_ACT: begin
          r_act <= w_act_last ? '0 : (r_act + C_ONE);
          if (w_act_last) r_g <= w_g_last ? '0 : (r_g + G_ONE);
        end
        S_OUT: begin
          if (w_j_last) begin
            r_j     <= '0;
            r_w     <= '0;
            r_xbase <= w_xb_next[AWIDTH-1:0];
            r_t     <= r_t + T_ONE;
          end else begin
            r_j <= r_j + H_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb/tb_lstm_seq_ctrl.sv - randomized bench for lstm_seq_ctrl against a loop-nest trace model
// The model expands t/j/gate/k loops into a per-cycle expected trace; stalls replay the head entry.
module tb_lstm_seq_ctrl;

  localparam int G  = 4;
  localparam int AL = 2;
  localparam int AW = 4;

  localparam int K_MAC  = 1;
  localparam int K_ACT  = 2;
  localparam int K_CELL = 3;
  localparam int K_OUT  = 4;
  localparam int K_DONE = 5;

  typedef struct {
    int kind;
    int op_sel;
    int op_addr;
    int w;
    int g;
    int j;
    int t;
    int clear;
    int afirst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [7:0]  in_size;
  logic [7:0]  hid_size;
  logic [9:0]  step_num;
  logic        stall;
  logic        busy;
  logic        ack;
  logic [1:0]  gate_sel;
  logic        op_sel;
  logic [3:0]  op_addr;
  logic [3:0]  w_addr;
  logic        mac_clear;
  logic        mac_en;
  logic        act_en;
  logic        cell_en;
  logic        h_we;
  logic [7:0]  h_addr;
  logic [9:0]  t_cnt;

  int checks   = 0;
  int failures = 0;
  ent_t q[$];

  lstm_seq_ctrl #(
    .GATES(G), .IWIDTH(8), .HWIDTH(8), .TWIDTH(10), .AWIDTH(AW), .ACT_LAT(AL)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .in_size(in_size), .hid_size(hid_size),
    .step_num(step_num), .stall(stall), .busy(busy), .ack(ack), .gate_sel(gate_sel),
    .op_sel(op_sel), .op_addr(op_addr), .w_addr(w_addr), .mac_clear(mac_clear),
    .mac_en(mac_en), .act_en(act_en), .cell_en(cell_en), .h_we(h_we),
    .h_addr(h_addr), .t_cnt(t_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, ack, gate_sel, op_sel, op_addr, w_addr, mac_clear, mac_en,
                act_en, cell_en, h_we, h_addr, t_cnt});
  endfunction

  function automatic logic [63:0] ctl_obs();
    return 64'({busy, ack, mac_clear, mac_en, act_en, cell_en, h_we});
  endfunction

  function automatic logic [63:0] ctl_exp(input ent_t e, input bit st);
    return 64'({1'b1, (e.kind == K_DONE) && !st, (e.kind == K_MAC) && (e.clear != 0) && !st,
                (e.kind == K_MAC) && !st, (e.kind == K_ACT) && (e.afirst != 0) && !st,
                (e.kind == K_CELL) && !st, (e.kind == K_OUT) && !st});
  endfunction

  task automatic push(input int kind, input int sel, input int addr, input int w, input int g,
                      input int j, input int t, input int clr, input int af);
    ent_t e;
    e.kind = kind; e.op_sel = sel; e.op_addr = addr; e.w = w; e.g = g;
    e.j = j; e.t = t; e.clear = clr; e.afirst = af;
    q.push_back(e);
  endtask

  task automatic build(input int ni, input int nh, input int ns);
    int w;
    q.delete();
    if (nh > 0 && ns > 0) begin
      for (int t = 0; t < ns; t++) begin
        w = 0;
        for (int j = 0; j < nh; j++) begin
          for (int g = 0; g < G; g++) begin
            for (int k = 0; k < ni + nh; k++) begin
              if (k < ni) push(K_MAC, 0, t * ni + k, w, g, j, t, (k == 0) ? 1 : 0, 0);
              else        push(K_MAC, 1, k - ni, w, g, j, t, (k == 0) ? 1 : 0, 0);
              w++;
            end
            for (int a = 0; a < AL; a++) push(K_ACT, 0, 0, 0, g, j, t, 0, (a == 0) ? 1 : 0);
          end
          push(K_CELL, 0, 0, 0, 0, j, t, 0, 0);
          push(K_OUT, 0, 0, 0, 0, j, t, 0, 0);
        end
      end
    end
    push(K_DONE, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run(input int ni, input int nh, input int ns, input int mode, input bit poke);
    ent_t e;
    int cyc, nst, ackc, nclr, nhwe, nmac, s1, s2, npop, base, rows;
    build(ni, nh, ns);
    cyc = 0; nst = 0; ackc = -1; nclr = 0; nhwe = 0; nmac = 0; s1 = 0; s2 = 0; npop = 0;
    @(negedge clk);
    req = 1'b1; in_size = 8'(ni); hid_size = 8'(nh); step_num = 10'(ns); stall = 1'b0;
    while (q.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      req = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (poke) begin
        in_size  = 8'($urandom_range(0, 255));
        hid_size = 8'($urandom_range(0, 255));
        step_num = 10'($urandom_range(0, 1023));
      end
      e = q[0];
      stall = 1'b0;
      if (mode == 1) stall = ($urandom_range(0, 3) == 0);
      else if (mode == 2) begin
        if (e.kind == K_MAC && npop >= 1 && s1 < 5) begin stall = 1'b1; s1++; end
        else if (e.kind == K_ACT && s2 < 3) begin stall = 1'b1; s2++; end
      end
      #1;
      chk("ctl", ctl_obs(), ctl_exp(e, stall));
      if (e.kind == K_MAC)
        chk("mac", 64'({op_sel, op_addr, w_addr, gate_sel, t_cnt}),
            64'({1'(e.op_sel), 4'(e.op_addr), 4'(e.w), 2'(e.g), 10'(e.t)}));
      if (e.kind == K_ACT) chk("gate", 64'(gate_sel), 64'(e.g));
      if (e.kind == K_OUT) chk("out", 64'({h_addr, t_cnt}), 64'({8'(e.j), 10'(e.t)}));
      if (ack) ackc = cyc;
      if (mac_clear) nclr++;
      if (h_we) nhwe++;
      if (mac_en) nmac++;
      if (stall) nst++;
      else begin
        void'(q.pop_front());
        npop++;
      end
    end
    if (q.size() > 0) chk("timeout", 64'(q.size()), 64'd0);
    rows = (nh > 0 && ns > 0) ? ns * nh : 0;
    base = (rows == 0) ? 1 : ns * nh * (G * (ni + nh + AL) + 2) + 1;
    chk("ack_lat", 64'(ackc), 64'(base + nst));
    chk("n_clear", 64'(nclr), 64'(rows * G));
    chk("n_hwe", 64'(nhwe), 64'(rows));
    chk("n_mac", 64'(nmac), 64'(rows * G * (ni + nh)));
    @(negedge clk);
    req = 1'b0; stall = 1'b0;
    #1;
    chk("idle", ctl_obs(), 64'd0);
  endtask

  task automatic reset_mid_act();
    bit found;
    found = 1'b0;
    @(negedge clk);
    req = 1'b1; in_size = 8'd3; hid_size = 8'd2; step_num = 10'd3; stall = 1'b0;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (act_en && t_cnt == 10'd1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("find_act", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rst_mid", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; stall = 1'b0;
    in_size = '0; hid_size = '0; step_num = '0;
    repeat (2) @(negedge clk);
    #1 chk("reset", all_outs(), 64'd0);
    rst = 1'b0;

    run(2, 1, 1, 0, 1'b0);
    run(3, 2, 3, 0, 1'b0);
    run(2, 0, 2, 0, 1'b0);
    run(2, 1, 0, 0, 1'b0);
    run(0, 2, 2, 0, 1'b0);
    run(2, 1, 1, 2, 1'b0);
    run(3, 2, 3, 1, 1'b1);
    reset_mid_act();
    run(3, 2, 3, 0, 1'b0);
    for (int n = 0; n < 14; n++)
      run(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
